wall_clk_sched: RTL and testbench
=================================

# wall_clk_sched

Shared-timer scheduler for the custom CPU wrapper's microsecond wall-clock counter. It lets `NUM_REQ` requesters measure elapsed intervals on a single counter instance. It serialises their results onto one valid/ready output port in round-robin order. It also owns the counter's `cnt_clear` line, issuing a clear only when no measurement is in flight.

## Interface
- `NUM_REQ`, 4: number of requester channels (2..16).
- `ID_W`, 2: width of `res_id`; must satisfy 2^ID_W >= NUM_REQ.
- `clk` in 1: system clock, 100 MHz.
- `resetn` in 1: reset, synchronous, active-low; one clock domain only.
- `cnt_val` in 32: microsecond count from the wall-clock counter.
- `cnt_clear` out 1: one-cycle clear pulse to the wall-clock counter.
- `req_start` in NUM_REQ: per-channel start pulse.
- `req_stop` in NUM_REQ: per-channel stop pulse.
- `ch_busy` out NUM_REQ: channel is not IDLE (RUN or DONE).
- `clr_req` in 1: request a counter clear (pulse).
- `clr_busy` out 1: clear pending or being issued.
- `res_valid` out 1: result available.
- `res_ready` in 1: consumer accepts result.
- `res_id` out ID_W: channel that produced the result.
- `res_elapsed` out 32: elapsed microseconds.

## Operation
- Each channel runs its own FSM: IDLE, RUN, DONE. Each channel also has a 32-bit timestamp register and a 32-bit elapsed register.
- IDLE:
  - `req_start` with `clr_busy`=0: latch `cnt_val` as the timestamp and go to RUN.
  - `req_start` with `clr_busy`=1: ignored.
  - `req_stop`: ignored.
- RUN:
  - `req_stop`: elapsed = `cnt_val` − timestamp, modulo 2^32, so counter wrap is correct. Go to DONE.
  - `req_start` without `req_stop`: re-latch the timestamp (restart). Stay in RUN.
  - `req_start` and `req_stop` in the same cycle: stop wins.
- DONE: `req_start` and `req_stop` are ignored. The channel leaves DONE (to IDLE) on the edge where its result is loaded into the output register.
- Output register: holds `res_valid`, `res_id` and `res_elapsed`.
  - It loads when it is empty (`res_valid`=0) or draining (`res_valid`&&`res_ready`) and at least one channel is in DONE.
  - Selection is round-robin: search DONE channels starting at `rr_ptr`. After loading channel k, `rr_ptr` = (k+1) mod NUM_REQ.
  - On handshake with no DONE channel, `res_valid` goes to 0.
  - While `res_valid`=1 and `res_ready`=0, all three output fields hold stable.
- Clear sequencing:
  - `clr_req` sets `clr_pending`.
  - If `clr_pending` is set and no channel is in RUN, the block asserts `cnt_clear` for exactly one cycle and clears `clr_pending` on the same edge.
  - `clr_req` arriving while `clr_pending` or `cnt_clear` is set is merged; no second pulse is produced.
  - `clr_busy` = `clr_pending` | `cnt_clear`.
  - DONE channels do not block a clear.
- Reset: all channels go to IDLE, timestamps and elapsed registers to 0, `rr_ptr`=0, `clr_pending`=0. All outputs (`cnt_clear`, `ch_busy`, `clr_busy`, `res_valid`, `res_id`, `res_elapsed`) reset to 0. Reset mid-measurement discards everything and emits no `cnt_clear`.

## Timing
- All state and outputs are registered. `ch_busy` and `clr_busy` are decoded directly from registers.
- Start/stop: sampled at edge E. The channel state changes after E, and `ch_busy` reflects it in the cycle after E.
- Stop-to-result: stop sampled at edge E gives DONE after E. With an empty output register, the result loads at E+1, and `res_valid`=1 from E+1. Minimum latency is 2 cycles.
- Result throughput: one result per cycle while `res_ready`=1 and results remain pending.
- Clear:
  - `clr_req` at edge E with no RUN channel: `cnt_clear`=1 for the cycle after E+1.
  - The counter reads 0 one cycle after `cnt_clear`.
  - `clr_busy` drops together with `cnt_clear`. A start accepted then latches the post-clear value.
- Stop sampled on the same edge that sets `cnt_clear`: counts as completing first, using the pre-clear `cnt_val`.

## Test plan
- Single interval: ch0 start at `cnt_val`=100, stop at `cnt_val`=357 -> `res_valid` 2 cycles after stop, `res_id`=0, `res_elapsed`=257.
- Wrap: ch1 start at 0xFFFF_FFF0, stop at 0x0000_0010 -> `res_elapsed`=0x20.
- Round-robin with backpressure: ch0, ch2 and ch3 stop on the same cycle, `res_ready`=0 for 5 cycles, then held at 1 -> outputs stable during the stall; order is 0, 2, 3; next burst starting from ch1/ch2 gives 2 before 0.
- Restart and same-cycle priority: ch0 start@10, start@50, stop@80 -> elapsed 30. In RUN, start and stop in the same cycle -> stop wins. In DONE, start is ignored and `ch_busy[0]` stays 1.
- Clear deferral: ch1 in RUN, `clr_req` pulsed twice -> no `cnt_clear` and `clr_busy`=1. A start on ch2 while `clr_busy`=1 is ignored. ch1 stops -> exactly one `cnt_clear` pulse, and ch1's result uses the pre-clear value.
- Reset mid-operation: two channels RUN, one result stalled, then `resetn`=0 for one cycle -> all outputs 0, no result emitted, `rr_ptr`=0.

Source files
------------

// File: rtl/wall_clk_sched_if.sv
// Result port of the wall-clock scheduler: one valid/ready stream carrying
// the producing channel id and its elapsed microsecond count.
interface wall_clk_sched_if #(
   parameter int unsigned ID_W = 2
) ();
   logic            res_valid;
   logic            res_ready;
   logic [ID_W-1:0] res_id;
   logic [31:0]     res_elapsed;

   modport master (
      output res_valid,
      output res_id,
      output res_elapsed,
      input  res_ready
   );

   modport slave (
      input  res_valid,
      input  res_id,
      input  res_elapsed,
      output res_ready
   );
endinterface

// File: rtl/wall_clk_sched.sv
// Shares one microsecond wall-clock counter among NUM_REQ interval timers,
// streams results round-robin and defers counter clears until no channel runs.
module wall_clk_sched #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ID_W    = 2
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic [31:0]        cnt_val,
   output logic               cnt_clear,
   input  logic [NUM_REQ-1:0] req_start,
   input  logic [NUM_REQ-1:0] req_stop,
   output logic [NUM_REQ-1:0] ch_busy,
   input  logic               clr_req,
   output logic               clr_busy,
   wall_clk_sched_if.master   res
);

   typedef enum logic [1:0] {StIdle, StRun, StDone} ch_state_e;

   ch_state_e       state_q [NUM_REQ];
   ch_state_e       state_d [NUM_REQ];
   logic [31:0]     ts_q    [NUM_REQ];
   logic [31:0]     ts_d    [NUM_REQ];
   logic [31:0]     el_q    [NUM_REQ];
   logic [31:0]     el_d    [NUM_REQ];
   logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
   logic            clr_pending_q, clr_pending_d;
   logic            cnt_clear_q, cnt_clear_d;
   logic            res_valid_q, res_valid_d;
   logic [ID_W-1:0] res_id_q, res_id_d;
   logic [31:0]     res_el_q, res_el_d;

   logic            any_run;
   logic            found;
   logic            load;
   logic [ID_W-1:0] sel;
   logic [31:0]     sel_el;
   int unsigned     idx;

   assign clr_busy        = clr_pending_q | cnt_clear_q;
   assign cnt_clear       = cnt_clear_q;
   assign res.res_valid   = res_valid_q;
   assign res.res_id      = res_id_q;
   assign res.res_elapsed = res_el_q;

   // Status decode and round-robin search over DONE channels from rr_ptr.
   always_comb begin
      any_run = 1'b0;
      ch_busy = '0;
      found   = 1'b0;
      sel     = '0;
      sel_el  = '0;
      idx     = 0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         ch_busy[i] = (state_q[i] != StIdle);
         if (state_q[i] == StRun) any_run = 1'b1;
      end
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
         idx = (32'(rr_ptr_q) + j) % NUM_REQ;
         if (!found && state_q[idx] == StDone) begin
            found  = 1'b1;
            sel    = ID_W'(idx);
            sel_el = el_q[idx];
         end
      end
      load = found && (!res_valid_q || res.res_ready);
   end

   always_comb begin
      state_d = state_q;
      ts_d    = ts_q;
      el_d    = el_q;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         case (state_q[i])
            StIdle: begin
               if (req_start[i] && !clr_busy) begin
                  ts_d[i]    = cnt_val;
                  state_d[i] = StRun;
               end
            end
            StRun: begin
               // Stop beats a simultaneous restart; subtraction wraps mod 2^32.
               if (req_stop[i]) begin
                  el_d[i]    = cnt_val - ts_q[i];
                  state_d[i] = StDone;
               end else if (req_start[i]) begin
                  ts_d[i] = cnt_val;
               end
            end
            StDone: begin
               if (load && 32'(sel) == i) state_d[i] = StIdle;
            end
            default: state_d[i] = StIdle;
         endcase
      end
   end

   always_comb begin
      res_valid_d   = res_valid_q;
      res_id_d      = res_id_q;
      res_el_d      = res_el_q;
      rr_ptr_d      = rr_ptr_q;
      clr_pending_d = clr_pending_q;
      cnt_clear_d   = 1'b0;
      if (load) begin
         res_valid_d = 1'b1;
         res_id_d    = sel;
         res_el_d    = sel_el;
         rr_ptr_d    = ID_W'((32'(sel) + 32'd1) % NUM_REQ);
      end else if (res.res_ready) begin
         res_valid_d = 1'b0;
      end
      // Requests arriving while a clear is pending or pulsing merge into it.
      if (clr_pending_q && !any_run) begin
         clr_pending_d = 1'b0;
         cnt_clear_d   = 1'b1;
      end else if (clr_req && !cnt_clear_q) begin
         clr_pending_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         for (int unsigned i = 0; i < NUM_REQ; i++) begin
            state_q[i] <= StIdle;
            ts_q[i]    <= '0;
            el_q[i]    <= '0;
         end
         rr_ptr_q      <= '0;
         clr_pending_q <= 1'b0;
         cnt_clear_q   <= 1'b0;
         res_valid_q   <= 1'b0;
         res_id_q      <= '0;
         res_el_q      <= '0;
      end else begin
         state_q       <= state_d;
         ts_q          <= ts_d;
         el_q          <= el_d;
         rr_ptr_q      <= rr_ptr_d;
         clr_pending_q <= clr_pending_d;
         cnt_clear_q   <= cnt_clear_d;
         res_valid_q   <= res_valid_d;
         res_id_q      <= res_id_d;
         res_el_q      <= res_el_d;
      end
   end

endmodule

// File: tb/tb_wall_clk_sched.sv
// Directed bench for wall_clk_sched: intervals, wrap, round-robin with stall,
// restart/priority, clear deferral and merging, and mid-operation reset.
module tb_wall_clk_sched;
   localparam int unsigned NUM_REQ = 4;
   localparam int unsigned ID_W    = 2;

   logic               clk       = 1'b0;
   logic               resetn    = 1'b0;
   logic [31:0]        cnt_val   = '0;
   logic               cnt_clear;
   logic [NUM_REQ-1:0] req_start = '0;
   logic [NUM_REQ-1:0] req_stop  = '0;
   logic [NUM_REQ-1:0] ch_busy;
   logic               clr_req   = 1'b0;
   logic               clr_busy;

   int errors       = 0;
   int checks       = 0;
   int clear_pulses = 0;
   int base;

   wall_clk_sched_if #(.ID_W(ID_W)) res_if ();

   wall_clk_sched #(
      .NUM_REQ(NUM_REQ),
      .ID_W   (ID_W)
   ) dut (
      .clk      (clk),
      .resetn   (resetn),
      .cnt_val  (cnt_val),
      .cnt_clear(cnt_clear),
      .req_start(req_start),
      .req_stop (req_stop),
      .ch_busy  (ch_busy),
      .clr_req  (clr_req),
      .clr_busy (clr_busy),
      .res      (res_if)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (cnt_clear === 1'b1) clear_pulses++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic start_ch(input logic [3:0] m, input logic [31:0] v);
      cnt_val   = v;
      req_start = m;
      step(1);
      req_start = '0;
   endtask

   task automatic stop_ch(input logic [3:0] m, input logic [31:0] v);
      cnt_val  = v;
      req_stop = m;
      step(1);
      req_stop = '0;
   endtask

   task automatic check_res(input string tag, input logic [31:0] id, input logic [31:0] el);
      check({tag, "_valid"}, 32'(res_if.res_valid), 32'd1);
      check({tag, "_id"}, 32'(res_if.res_id), id);
      check({tag, "_el"}, res_if.res_elapsed, el);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_valid"}, 32'(res_if.res_valid), 32'd0);
      check({tag, "_id"}, 32'(res_if.res_id), 32'd0);
      check({tag, "_el"}, res_if.res_elapsed, 32'd0);
      check({tag, "_busy"}, 32'(ch_busy), 32'd0);
      check({tag, "_clrbusy"}, 32'(clr_busy), 32'd0);
      check({tag, "_cntclr"}, 32'(cnt_clear), 32'd0);
   endtask

   initial begin
      res_if.res_ready = 1'b0;
      step(2);
      check_idle_outputs("reset");
      resetn = 1'b1;
      step(1);

      // Single interval on ch0: 357 - 100.
      start_ch(4'b0001, 32'd100);
      check("t1_busy_run", 32'(ch_busy), 32'h1);
      stop_ch(4'b0001, 32'd357);
      check("t1_novalid_yet", 32'(res_if.res_valid), 32'd0);
      check("t1_busy_done", 32'(ch_busy), 32'h1);
      step(1);
      check_res("t1", 32'd0, 32'd257);
      check("t1_busy_idle", 32'(ch_busy), 32'h0);
      res_if.res_ready = 1'b1;
      step(1);
      check("t1_drained", 32'(res_if.res_valid), 32'd0);

      // Counter wrap on ch1.
      start_ch(4'b0010, 32'hFFFF_FFF0);
      stop_ch(4'b0010, 32'h0000_0010);
      step(1);
      check_res("wrap", 32'd1, 32'h20);
      step(1);
      check("wrap_drained", 32'(res_if.res_valid), 32'd0);

      // ch3 result moves rr_ptr back to 0.
      start_ch(4'b1000, 32'd5);
      stop_ch(4'b1000, 32'd12);
      step(1);
      check_res("ch3", 32'd3, 32'd7);
      step(1);

      // Round-robin burst 0,2,3 under backpressure.
      res_if.res_ready = 1'b0;
      start_ch(4'b0001, 32'd0);
      start_ch(4'b0100, 32'd10);
      start_ch(4'b1000, 32'd20);
      stop_ch(4'b1101, 32'd100);
      step(1);
      check_res("rr_first", 32'd0, 32'd100);
      for (int k = 0; k < 4; k++) begin
         step(1);
         check_res("rr_stall", 32'd0, 32'd100);
      end
      res_if.res_ready = 1'b1;
      step(1);
      check_res("rr_second", 32'd2, 32'd90);
      step(1);
      check_res("rr_third", 32'd3, 32'd80);
      step(1);
      check("rr_drained", 32'(res_if.res_valid), 32'd0);

      // ch1 result leaves rr_ptr at 2, so ch2 precedes ch0.
      start_ch(4'b0010, 32'd0);
      stop_ch(4'b0010, 32'd33);
      step(1);
      check_res("rr_ch1", 32'd1, 32'd33);
      start_ch(4'b0001, 32'd1000);
      start_ch(4'b0100, 32'd1200);
      stop_ch(4'b0101, 32'd1500);
      step(1);
      check_res("rr2_first", 32'd2, 32'd300);
      step(1);
      check_res("rr2_second", 32'd0, 32'd500);
      step(1);
      check("rr2_drained", 32'(res_if.res_valid), 32'd0);

      // Restart, same-cycle stop priority, start ignored in DONE.
      res_if.res_ready = 1'b0;
      start_ch(4'b0001, 32'd10);
      start_ch(4'b0001, 32'd50);
      stop_ch(4'b0001, 32'd80);
      step(1);
      check_res("restart", 32'd0, 32'd30);
      start_ch(4'b0001, 32'd200);
      cnt_val   = 32'd260;
      req_start = 4'b0001;
      req_stop  = 4'b0001;
      step(1);
      req_start = '0;
      req_stop  = '0;
      check("prio_done_busy", 32'(ch_busy), 32'h1);
      check_res("prio_hold", 32'd0, 32'd30);
      start_ch(4'b0001, 32'd300);
      check("done_start_busy", 32'(ch_busy), 32'h1);
      res_if.res_ready = 1'b1;
      step(1);
      check_res("prio", 32'd0, 32'd60);
      step(1);
      check("prio_drained", 32'(res_if.res_valid), 32'd0);
      check("prio_idle", 32'(ch_busy), 32'h0);

      // Clear deferred behind a running channel; two requests merge.
      base = clear_pulses;
      start_ch(4'b0010, 32'd400);
      clr_req = 1'b1;
      step(1);
      clr_req = 1'b0;
      step(1);
      clr_req = 1'b1;
      step(1);
      clr_req = 1'b0;
      step(1);
      check("defer_cntclr", 32'(cnt_clear), 32'd0);
      check("defer_clrbusy", 32'(clr_busy), 32'd1);
      start_ch(4'b0100, 32'd420);
      check("defer_start_ignored", 32'(ch_busy), 32'h2);
      stop_ch(4'b0010, 32'd450);
      check("defer_stop_cntclr", 32'(cnt_clear), 32'd0);
      check("defer_stop_clrbusy", 32'(clr_busy), 32'd1);
      step(1);
      check("clr_pulse", 32'(cnt_clear), 32'd1);
      check_res("preclear", 32'd1, 32'd50);
      cnt_val = 32'd0;
      step(1);
      check("clr_pulse_end", 32'(cnt_clear), 32'd0);
      check("clr_busy_end", 32'(clr_busy), 32'd0);
      check("clr_pulse_count", 32'(clear_pulses - base), 32'd1);
      start_ch(4'b0100, 32'd3);
      check("post_clear_start", 32'(ch_busy), 32'h4);

      // Reset with ch2/ch3 running, ch1 result stalled, clear pending.
      res_if.res_ready = 1'b0;
      start_ch(4'b0010, 32'd10);
      stop_ch(4'b0010, 32'd25);
      step(1);
      check_res("pre_reset", 32'd1, 32'd15);
      start_ch(4'b1000, 32'd30);
      clr_req = 1'b1;
      step(1);
      clr_req = 1'b0;
      check("pre_reset_clrbusy", 32'(clr_busy), 32'd1);
      base   = clear_pulses;
      resetn = 1'b0;
      step(1);
      resetn = 1'b1;
      check_idle_outputs("midreset");
      step(3);
      check("midreset_no_clear", 32'(clear_pulses - base), 32'd0);
      check("midreset_no_result", 32'(res_if.res_valid), 32'd0);

      // rr_ptr back at 0: ch1 ahead of ch3.
      res_if.res_ready = 1'b1;
      start_ch(4'b0010, 32'd100);
      start_ch(4'b1000, 32'd110);
      stop_ch(4'b1010, 32'd140);
      step(1);
      check_res("ptr0_first", 32'd1, 32'd40);
      step(1);
      check_res("ptr0_second", 32'd3, 32'd30);
      step(1);
      check("ptr0_drained", 32'(res_if.res_valid), 32'd0);

      // Idle clear timing and merging during the pulse.
      base    = clear_pulses;
      clr_req = 1'b1;
      step(1);
      check("idle_clr_wait", 32'(cnt_clear), 32'd0);
      check("idle_clr_busy", 32'(clr_busy), 32'd1);
      step(1);
      check("idle_clr_pulse", 32'(cnt_clear), 32'd1);
      step(1);
      clr_req = 1'b0;
      check("idle_clr_end", 32'(cnt_clear), 32'd0);
      check("idle_clr_busy_end", 32'(clr_busy), 32'd0);
      step(3);
      check("idle_clr_count", 32'(clear_pulses - base), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
